instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: FIFO_DEPTH, default 2, instruction buffer entries; SHALL be 2 or 4.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_en  output  1  instruction-memory read strobe.
REQ-006 imem_addr  output  32  word-aligned read address.
REQ-007 imem_rdata  input  32  read data, valid exactly one cycle after imem_en high.
REQ-008 redirect_valid  input  1  branch/jump redirect request from execute.
REQ-009 redirect_pc  input  32  redirect target.
REQ-010 instr  output  32  instruction presented to decoder (FIFO head).
REQ-011 instr_pc  output  32  address of instr.
REQ-012 instr_valid  output  1  instr/instr_pc valid.
REQ-013 instr_ready  input  1  decoder accepts head this cycle.
REQ-014 fetch_fault  output  1  misaligned-target fault (meaningful only with FETCH_MISALIGN_EN).

Function
REQ-015 Handshake: head transfers when instr_valid && instr_ready; instr, instr_pc held stable while instr_valid && !instr_ready.
REQ-016 FSM states: BOOT, FETCH, HOLD.
REQ-017 BOOT: entered on reset; imem_en=0; advances to FETCH next cycle.
REQ-018 FETCH: imem_en=1, imem_addr=pc; pc += 4 each issuing cycle; enter HOLD when occupancy + in-flight would reach FIFO_DEPTH.
REQ-019 HOLD: imem_en=0; return to FETCH the cycle after occupancy + in-flight < FIFO_DEPTH.
REQ-020 A response returning one cycle after issue SHALL be written to FIFO tail with its issue address; no response is ever dropped for lack of space.
REQ-021 Empty FIFO with response arriving: instr_valid rises the cycle after imem_rdata is sampled (fetch-to-valid latency 2 cycles from imem_en).
REQ-022 Simultaneous push and pop SHALL keep occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-023 redirect_valid (any state except BOOT): flush FIFO, instr_valid=0 next cycle, squash the in-flight response (epoch bit toggles; stale-epoch data discarded), pc=redirect_pc, state=FETCH, and fetch redirect_pc the following cycle.
REQ-024 Redirect coinciding with handshake: the pop completes; the flush still applies.
REQ-025 Redirect SHALL take priority over HOLD and over any push in the same cycle.
REQ-026 pc wraps from 32'hFFFF_FFFC to 32'h0000_0000 without fault.

Reset
REQ-027 On reset: state=BOOT, pc=RESET_PC, FIFO empty, epoch=0, instr_valid=0, imem_en=0, imem_addr=RESET_PC, instr=0, instr_pc=0, fetch_fault=0.
REQ-028 Reset mid-operation SHALL discard all buffered and in-flight data; no pre-reset data appears on instr.
REQ-029 reset overrides redirect_valid in the same cycle.

Configuration
REQ-030 Macro FETCH_MISALIGN_EN defined: redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until reset), FIFO flushed, no further imem_en, instr_valid stays 0.
REQ-031 Macro undefined: redirect_pc[1:0] forced to 2'b00 and fetched; fetch_fault tied 0.

Verification
REQ-032 Reset release, RESET_PC=0, instr_ready=1 -> imem_addr 0,4,8,... one per cycle; first instr_valid with instr_pc=0 two cycles after first imem_en.
REQ-033 instr_ready=0 for 10 cycles -> imem_en drops within FIFO_DEPTH cycles, instr/instr_pc frozen at pc 0; on release, pcs 0,4,8 delivered in order with no gap or duplicate.
REQ-034 redirect_valid with redirect_pc=32'h100 while response for 0x8 is in flight -> 0x8 never presented; next valid instr_pc=32'h100.
REQ-035 Redirect in the same cycle as a handshake with a full FIFO -> popped entry counted once; next instr_pc = redirect target.
REQ-036 reset asserted mid-stream with a full FIFO -> next cycle instr_valid=0; first fetch after release at RESET_PC.
REQ-037 With FETCH_MISALIGN_EN, redirect_pc=32'h102 -> fetch_fault=1 next cycle, imem_en=0 thereafter; without the macro, imem_addr=32'h100.

Source files
------------

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch front end. It issues word-aligned reads to a
//   single-cycle instruction memory. Returned words go into a small in-order
//   buffer, and the buffer head is presented to the decoder through a
//   valid/ready handshake. A redirect from execute flushes the buffer and
//   squashes the read that is still in flight, then restarts fetch at the
//   redirect target.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  instruction buffer entries (2 or 4)
//
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous, active-high reset
//   imem_en         instruction-memory read strobe
//   imem_addr       word-aligned read address
//   imem_rdata      read data, valid exactly one cycle after imem_en
//   redirect_valid  branch/jump redirect request
//   redirect_pc     redirect target
//   instr           buffer head instruction (0 when not valid)
//   instr_pc        address of instr (0 when not valid)
//   instr_valid     instr/instr_pc valid
//   instr_ready     decoder accepts the head this cycle
//   fetch_fault     misaligned redirect target seen (sticky until reset)
//
// Build option
//   FETCH_MISALIGN_EN  defined: a redirect target with redirect_pc[1:0] != 0
//                      raises fetch_fault, flushes the buffer and stops fetch.
//                      Undefined: the low two target bits are forced to zero
//                      and fetch_fault is tied low.
//
// FSM
//   state | meaning
//   BOOT  | first cycle after reset, no fetch issued
//   FETCH | one read issued per cycle at pc
//   HOLD  | no read issued: buffer plus in-flight read would overflow,
//         | or fetch is stopped after a fault
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_fault
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            epoch_q, epoch_d;
    logic            infl_q, infl_d;
    logic [31:0]     infl_pc_q, infl_pc_d;
    logic            infl_epoch_q, infl_epoch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            fault_q, fault_d;

    logic [31:0]     mem_data_q [FIFO_DEPTH];
    logic [31:0]     mem_pc_q   [FIFO_DEPTH];
    logic            mem_we;

    logic            issue;
    logic            pop;
    logic            push_live;
    logic            push;
    logic            redir_take;
    logic            misalign;
    logic [31:0]     redir_tgt;
    logic [CW-1:0]   occ_nxt;

`ifdef FETCH_MISALIGN_EN
    assign misalign  = (redirect_pc[1:0] != 2'b00);
    assign redir_tgt = redirect_pc;
`else
    logic unused_redir_lo;
    assign unused_redir_lo = ^redirect_pc[1:0];
    assign misalign        = 1'b0;
    assign redir_tgt       = {redirect_pc[31:2], 2'b00};
`endif

    assign issue       = (state_q == FETCH);
    assign instr_valid = (cnt_q != '0);
    assign pop         = instr_valid && instr_ready;

    // A returning word is kept only if it was issued in the current epoch;
    // anything issued before the last redirect is discarded.
    assign push_live   = infl_q && (infl_epoch_q == epoch_q);
    assign redir_take  = redirect_valid && (state_q != BOOT) && !fault_q;
    assign push        = push_live && !redir_take;

    // Occupancy at the end of this cycle, ignoring any redirect.
    assign occ_nxt     = cnt_q + CW'(push_live) - CW'(pop);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epoch_d      = epoch_q;
        infl_d       = 1'b0;
        infl_pc_d    = pc_q;
        infl_epoch_d = epoch_q;
        cnt_d        = occ_nxt;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fault_d      = fault_q;
        mem_we       = 1'b0;

        if (issue) begin
            infl_d = 1'b1;
            pc_d   = pc_q + 32'd4;
        end

        if (push) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // The read issued now lands one cycle later and must always have a
        // slot, whatever the decoder does in between, so fetch stops when
        // the buffer plus this read would fill it.
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                if ((occ_nxt + CW'(1)) >= DEPTH_C) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!fault_q && (occ_nxt < DEPTH_C)) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // A redirect wins over throttling and over a push in the same cycle.
        // A pop in the same cycle has already been taken by the decoder.
        if (redir_take) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            mem_we   = 1'b0;
            epoch_d  = ~epoch_q;
            pc_d     = redir_tgt;
            if (misalign) begin
                fault_d = 1'b1;
                state_d = HOLD;
            end else begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            epoch_q      <= 1'b0;
            infl_q       <= 1'b0;
            infl_pc_q    <= '0;
            infl_epoch_q <= 1'b0;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epoch_q      <= epoch_d;
            infl_q       <= infl_d;
            infl_pc_q    <= infl_pc_d;
            infl_epoch_q <= infl_epoch_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fault_q      <= fault_d;
        end
    end

    // Buffer storage needs no reset: the outputs are masked while it is empty.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_data_q[wr_ptr_q] <= imem_rdata;
            mem_pc_q[wr_ptr_q]   <= infl_pc_q;
        end
    end

    assign imem_en   = issue;
    assign imem_addr = pc_q;
    assign instr     = instr_valid ? mem_data_q[rd_ptr_q] : 32'h0;
    assign instr_pc  = instr_valid ? mem_pc_q[rd_ptr_q]   : 32'h0;

`ifdef FETCH_MISALIGN_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] JUNK   = 32'hBAD0_0BAD;

    logic        clk;
    logic        reset;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] del_pc [$];

    instr_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .fetch_fault    (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // instruction memory: answers exactly one cycle after a strobe
    initial begin
        logic        e;
        logic [31:0] a;
        imem_rdata = JUNK;
        forever begin
            @(negedge clk);
            e = imem_en;
            a = imem_addr;
            @(posedge clk);
            #1;
            imem_rdata = e ? mem_word(a) : JUNK;
        end
    end

    // reference model: every strobed address of the current epoch must come
    // out on instr in order, exactly once, no earlier than 2 cycles after issue
    initial begin
        logic [31:0] q_pc [$];
        int          q_cyc [$];
        logic [31:0] exp_pc;
        int          cyc;
        logic        prev_rst, boot, faulted, exp_valid;
        logic        prev_valid, prev_ready, prev_redir;
        logic [31:0] prev_pc, prev_instr;
        cyc = 0; prev_rst = 1'b0; boot = 1'b0; faulted = 1'b0;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_redir = 1'b0;
        prev_pc = '0; prev_instr = '0; exp_pc = RST_PC;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_rst) begin
                chk("m_rst_valid", {31'b0, instr_valid}, 32'd0);
                chk("m_rst_en", {31'b0, imem_en}, 32'd0);
                chk("m_rst_addr", imem_addr, RST_PC);
                chk("m_rst_instr", instr, 32'd0);
                chk("m_rst_pc", instr_pc, 32'd0);
                chk("m_rst_fault", {31'b0, fetch_fault}, 32'd0);
            end
            if (reset) begin
                q_pc.delete(); q_cyc.delete();
                exp_pc = RST_PC; faulted = 1'b0;
                prev_rst = 1'b1; prev_valid = 1'b0; prev_redir = 1'b0;
                continue;
            end
            boot = prev_rst;
            chk("m_fault", {31'b0, fetch_fault}, {31'b0, faulted});
            exp_valid = (q_pc.size() > 0) && (q_cyc[0] + 2 <= cyc);
            chk("m_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
            if (instr_valid && exp_valid) begin
                chk("m_instr_pc", instr_pc, q_pc[0]);
                chk("m_instr", instr, mem_word(q_pc[0]));
            end
            if (prev_valid && !prev_ready && !prev_redir && !prev_rst) begin
                chk("m_hold_valid", {31'b0, instr_valid}, 32'd1);
                chk("m_hold_pc", instr_pc, prev_pc);
                chk("m_hold_instr", instr, prev_instr);
            end
            if (instr_valid && instr_ready && exp_valid) begin
                del_pc.push_back(q_pc[0]);
                void'(q_pc.pop_front());
                void'(q_cyc.pop_front());
            end
            if (boot || faulted) begin
                chk("m_no_fetch", {31'b0, imem_en}, 32'd0);
            end else if (imem_en) begin
                chk("m_addr", imem_addr, exp_pc);
                q_pc.push_back(imem_addr);
                q_cyc.push_back(cyc);
                exp_pc = exp_pc + 32'd4;
            end
            prev_redir = 1'b0;
            if (redirect_valid && !boot && !faulted) begin
                prev_redir = 1'b1;
                q_pc.delete(); q_cyc.delete();
`ifdef FETCH_MISALIGN_EN
                if (redirect_pc[1:0] != 2'b00) faulted = 1'b1;
                exp_pc = redirect_pc;
`else
                exp_pc = {redirect_pc[31:2], 2'b00};
`endif
            end
            prev_rst   = 1'b0;
            prev_valid = instr_valid;
            prev_ready = instr_ready;
            prev_pc    = instr_pc;
            prev_instr = instr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int en_cnt;
        int n0;
        logic seen8;
        reset = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) tick();
        chk("rst_en", {31'b0, imem_en}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

        // streaming from reset
        reset = 1'b0;
        del_pc.delete();
        chk("boot_en", {31'b0, imem_en}, 32'd0);
        tick(); chk("s1_en", {31'b0, imem_en}, 32'd1); chk("s1_addr", imem_addr, 32'h0);
        chk("s1_valid", {31'b0, instr_valid}, 32'd0);
        tick(); chk("s2_addr", imem_addr, 32'h4); chk("s2_valid", {31'b0, instr_valid}, 32'd0);
        tick(); chk("s3_addr", imem_addr, 32'h8); chk("s3_valid", {31'b0, instr_valid}, 32'd1);
        chk("s3_pc", instr_pc, 32'h0); chk("s3_instr", instr, 32'hC0DE_0000);
        tick(); chk("s4_addr", imem_addr, 32'hC); chk("s4_pc", instr_pc, 32'h4);

        // redirect while the read of 0x8 is returning
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick(); redirect_valid = 1'b0;
        chk("r1_valid", {31'b0, instr_valid}, 32'd0);
        chk("r1_addr", imem_addr, 32'h100);
        tick(); chk("r2_addr", imem_addr, 32'h104);
        tick(); chk("r3_valid", {31'b0, instr_valid}, 32'd1);
        chk("r3_pc", instr_pc, 32'h100); chk("r3_instr", instr, 32'hC0DE_0100);
        seen8 = 1'b0;
        foreach (del_pc[i]) if (del_pc[i] == 32'h8) seen8 = 1'b1;
        chk("r_no_0x8", {31'b0, seen8}, 32'd0);

        // decoder stall from reset release
        reset = 1'b1; tick(); tick();
        reset = 1'b0; instr_ready = 1'b0; en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (imem_en) en_cnt++;
            if (instr_valid) chk("stall_pc", instr_pc, 32'h0);
        end
        chk("stall_en_cycles", en_cnt, DEPTH);
        chk("stall_en_off", {31'b0, imem_en}, 32'd0);
        instr_ready = 1'b1;
        chk("rel0_pc", instr_pc, 32'h0);
        for (int k = 1; k < 6; k++) begin
            tick();
            chk("rel_valid", {31'b0, instr_valid}, 32'd1);
            chk("rel_pc", instr_pc, 32'(4 * k));
        end

        // redirect together with a handshake on a full buffer
        reset = 1'b1; tick(); tick();
        reset = 1'b0; instr_ready = 1'b0;
        repeat (7) tick();
        chk("full_pc", instr_pc, 32'h0);
        chk("full_en", {31'b0, imem_en}, 32'd0);
        del_pc.delete();
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick(); redirect_valid = 1'b0;
        chk("rh_valid", {31'b0, instr_valid}, 32'd0);
        chk("rh_addr", imem_addr, 32'h200);
        tick(); tick();
        chk("rh_pc", instr_pc, 32'h200);
        n0 = 0;
        foreach (del_pc[i]) if (del_pc[i] == 32'h0) n0++;
        chk("rh_pop_once", n0, 1);
        chk("rh_pops", del_pc.size(), 1);

        // reset with a full buffer
        instr_ready = 1'b0;
        repeat (8) tick();
        chk("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
        reset = 1'b1; tick();
        chk("mr_valid", {31'b0, instr_valid}, 32'd0);
        chk("mr_instr", instr, 32'h0);
        reset = 1'b0; instr_ready = 1'b1;
        chk("mr_boot_en", {31'b0, imem_en}, 32'd0);
        tick(); chk("mr_en", {31'b0, imem_en}, 32'd1); chk("mr_addr", imem_addr, RST_PC);
        tick(); tick(); chk("mr_first_pc", instr_pc, RST_PC);

        // pc wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick(); redirect_valid = 1'b0; del_pc.delete();
        chk("w1_addr", imem_addr, 32'hFFFF_FFF8);
        tick(); chk("w2_addr", imem_addr, 32'hFFFF_FFFC);
        tick(); chk("w3_addr", imem_addr, 32'h0000_0000);
        repeat (3) tick();
        chk("w_cnt", {31'b0, del_pc.size() >= 3}, 32'd1);
        if (del_pc.size() >= 3) begin
            chk("w_d0", del_pc[0], 32'hFFFF_FFF8);
            chk("w_d1", del_pc[1], 32'hFFFF_FFFC);
            chk("w_d2", del_pc[2], 32'h0000_0000);
        end

        // misaligned redirect target
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick(); redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_EN
        chk("ma_fault", {31'b0, fetch_fault}, 32'd1);
        chk("ma_en", {31'b0, imem_en}, 32'd0);
        repeat (3) tick();
        chk("ma_en_late", {31'b0, imem_en}, 32'd0);
        chk("ma_valid", {31'b0, instr_valid}, 32'd0);
        chk("ma_sticky", {31'b0, fetch_fault}, 32'd1);
`else
        chk("ma_fault", {31'b0, fetch_fault}, 32'd0);
        chk("ma_addr", imem_addr, 32'h100);
        tick(); tick();
        chk("ma_pc", instr_pc, 32'h100);
        chk("ma_instr", instr, 32'hC0DE_0100);
`endif
        reset = 1'b1; tick();
        chk("end_fault", {31'b0, fetch_fault}, 32'd0);
        reset = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
